// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings and
// the instruction address width derived from the instruction ROM depth.
package pipe_ctrl_pkg;

    localparam int ROM_DEPTH   = 4096;
    localparam int CTRL_ADDR_W = $clog2(ROM_DEPTH);
    localparam int FCNT_W      = 3;
    localparam int WD_W        = 8;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_FLUSH    = 2'd1,
        CTRL_WAIT_MC  = 2'd2,
        CTRL_WAIT_MEM = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use comparator: flags an ID instruction that reads the rd of a
// load still sitting in EX. x0 never creates a dependency.
module pipe_hazard_det (
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd_addr,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_used && (id_rs1_addr == ex_rd_addr);
    assign rs2_hit  = id_rs2_used && (id_rs2_addr == ex_rd_addr);
    assign load_use = ex_is_load && (ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: registered FSM (RUN/FLUSH/WAIT_MC/WAIT_MEM) with a
// flush counter and stall watchdog; hold/flush outputs decode state+inputs.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = CTRL_ADDR_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ex_is_load_i,
    input  logic [4:0]        ex_rd_addr_i,
    input  logic [4:0]        id_rs1_addr_i,
    input  logic [4:0]        id_rs2_addr_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic              mc_start_i,
    input  logic              mc_done_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              jump_en_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              hold_pc_o,
    output logic              hold_if2id_o,
    output logic              hold_id2exu_o,
    output logic              flush_if2id_o,
    output logic              flush_id2exu_o,
    output logic [1:0]        state_o,
    output logic              err_o
);

    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT     = WD_W'(TIMEOUT);

    ctrl_state_e       state_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic [WD_W-1:0]   wd_q;
    logic              err_q;

    logic load_use;
    logic stall_mem;
    logic stall_mc;
    logic wait_done;
    logic wd_expire;

    pipe_hazard_det u_hazard (
        .ex_is_load  (ex_is_load_i),
        .ex_rd_addr  (ex_rd_addr_i),
        .id_rs1_addr (id_rs1_addr_i),
        .id_rs2_addr (id_rs2_addr_i),
        .id_rs1_used (id_rs1_used_i),
        .id_rs2_used (id_rs2_used_i),
        .load_use    (load_use)
    );

    assign stall_mem = mem_req_i && !mem_ack_i;
    assign stall_mc  = mc_start_i && !mc_done_i;
    assign wait_done = (state_q == CTRL_WAIT_MEM) ? mem_ack_i : mc_done_i;
    // A completion arriving in the expiry cycle wins: the op did finish.
    assign wd_expire = (wd_q == WD_LIMIT) && !wait_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CTRL_RUN;
            fcnt_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                CTRL_RUN: begin
                    wd_q <= '0;
                    if (jump_en_i) begin
                        if (FLUSH_CYCLES > 1) begin
                            state_q <= CTRL_FLUSH;
                            fcnt_q  <= FLUSH_RELOAD;
                        end
                    end else if (stall_mem) begin
                        state_q <= CTRL_WAIT_MEM;
                        wd_q    <= WD_W'(1);
                    end else if (stall_mc) begin
                        state_q <= CTRL_WAIT_MC;
                        wd_q    <= WD_W'(1);
                    end
                end
                CTRL_FLUSH: begin
                    if (jump_en_i) begin
                        fcnt_q <= FLUSH_RELOAD;
                    end else if (fcnt_q <= FCNT_W'(1)) begin
                        state_q <= CTRL_RUN;
                        fcnt_q  <= '0;
                    end else begin
                        fcnt_q <= fcnt_q - FCNT_W'(1);
                    end
                end
                default: begin
                    // wd_q counts stalled cycles including the RUN entry cycle
                    if (wait_done) begin
                        state_q <= CTRL_RUN;
                        wd_q    <= '0;
                    end else if (wd_expire) begin
                        state_q <= CTRL_RUN;
                        wd_q    <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        jump_en_o      = 1'b0;
        jump_addr_o    = '0;
        hold_pc_o      = 1'b0;
        hold_if2id_o   = 1'b0;
        hold_id2exu_o  = 1'b0;
        flush_if2id_o  = 1'b0;
        flush_id2exu_o = 1'b0;
        if (!rst) begin
            case (state_q)
                CTRL_RUN: begin
                    if (jump_en_i) begin
                        jump_en_o      = 1'b1;
                        jump_addr_o    = jump_addr_i;
                        flush_if2id_o  = 1'b1;
                        flush_id2exu_o = 1'b1;
                    end else if (stall_mem || stall_mc) begin
                        hold_pc_o     = 1'b1;
                        hold_if2id_o  = 1'b1;
                        hold_id2exu_o = 1'b1;
                    end else if (load_use) begin
                        hold_pc_o      = 1'b1;
                        hold_if2id_o   = 1'b1;
                        flush_id2exu_o = 1'b1;
                    end
                end
                CTRL_FLUSH: begin
                    flush_if2id_o  = 1'b1;
                    flush_id2exu_o = 1'b1;
                    if (jump_en_i) begin
                        jump_en_o   = 1'b1;
                        jump_addr_o = jump_addr_i;
                    end
                end
                default: begin
                    if (wd_expire) begin
                        flush_if2id_o  = 1'b1;
                        flush_id2exu_o = 1'b1;
                    end else if (!wait_done) begin
                        hold_pc_o     = 1'b1;
                        hold_if2id_o  = 1'b1;
                        hold_id2exu_o = 1'b1;
                    end
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign err_o   = !rst && (err_q || ((state_q == CTRL_WAIT_MC || state_q == CTRL_WAIT_MEM) && wd_expire));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-by-cycle vector table plus
// hand-written watchdog and asynchronous-reset sequences.
module tb_pipe_ctrl;

    localparam int AW = 12;

    // expected control word: {jump_en, hold_pc, hold_if2id, hold_id2exu, flush_if2id, flush_id2exu, err}
    localparam logic [6:0] C_J   = 7'b1000000;
    localparam logic [6:0] C_ERR = 7'b0000001;
    localparam logic [6:0] HOLD3 = 7'b0111000;
    localparam logic [6:0] FL2   = 7'b0000110;
    localparam logic [6:0] BUB   = 7'b0110010;
    localparam logic [6:0] NONE  = 7'b0000000;

    // event inputs: {jump_en, mc_start, mc_done, mem_req, mem_ack}
    localparam logic [4:0] E_J   = 5'b10000;
    localparam logic [4:0] E_MCS = 5'b01000;
    localparam logic [4:0] E_MCD = 5'b00100;
    localparam logic [4:0] E_REQ = 5'b00010;
    localparam logic [4:0] E_ACK = 5'b00001;

    typedef struct {
        logic [4:0]    ev;
        logic [AW-1:0] ja;
        logic [17:0]   hz;   // {ld, rd, rs1, rs1_used, rs2, rs2_used}
        logic [1:0]    st;
        logic [6:0]    ctl;
        logic [AW-1:0] ea;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          jump_en_i;
    logic [AW-1:0] jump_addr_i;
    logic          ex_is_load_i;
    logic [4:0]    ex_rd_addr_i;
    logic [4:0]    id_rs1_addr_i;
    logic [4:0]    id_rs2_addr_i;
    logic          id_rs1_used_i;
    logic          id_rs2_used_i;
    logic          mc_start_i;
    logic          mc_done_i;
    logic          mem_req_i;
    logic          mem_ack_i;
    logic          jump_en_o;
    logic [AW-1:0] jump_addr_o;
    logic          hold_pc_o;
    logic          hold_if2id_o;
    logic          hold_id2exu_o;
    logic          flush_if2id_o;
    logic          flush_id2exu_o;
    logic [1:0]    state_o;
    logic          err_o;

    int n_run  = 0;
    int n_fail = 0;

    pipe_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(2), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_en_i      (jump_en_i),
        .jump_addr_i    (jump_addr_i),
        .ex_is_load_i   (ex_is_load_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .mc_start_i     (mc_start_i),
        .mc_done_i      (mc_done_i),
        .mem_req_i      (mem_req_i),
        .mem_ack_i      (mem_ack_i),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
        .hold_pc_o      (hold_pc_o),
        .hold_if2id_o   (hold_if2id_o),
        .hold_id2exu_o  (hold_id2exu_o),
        .flush_if2id_o  (flush_if2id_o),
        .flush_id2exu_o (flush_id2exu_o),
        .state_o        (state_o),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] hzv(input logic ld, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic u1,
                                        input logic [4:0] rs2, input logic u2);
        return {ld, rd, rs1, u1, rs2, u2};
    endfunction

    function automatic vec_t mk(input logic [4:0] ev, input logic [AW-1:0] ja,
                                input logic [17:0] hz, input logic [1:0] st,
                                input logic [6:0] ctl, input logic [AW-1:0] ea);
        vec_t v;
        v.ev = ev; v.ja = ja; v.hz = hz; v.st = st; v.ctl = ctl; v.ea = ea;
        return v;
    endfunction

    task automatic apply(input logic [4:0] ev, input logic [AW-1:0] ja, input logic [17:0] hz);
        {jump_en_i, mc_start_i, mc_done_i, mem_req_i, mem_ack_i} = ev;
        jump_addr_i = ja;
        {ex_is_load_i, ex_rd_addr_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i, id_rs2_used_i} = hz;
    endtask

    task automatic check(input string name, input logic [1:0] st, input logic [6:0] ctl,
                         input logic [AW-1:0] ea);
        logic [6:0] got;
        got = {jump_en_o, hold_pc_o, hold_if2id_o, hold_id2exu_o, flush_if2id_o, flush_id2exu_o, err_o};
        n_run++;
        if (state_o !== st || got !== ctl || jump_addr_o !== ea) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ctl=%b addr=%h, expected state=%0d ctl=%b addr=%h",
                     name, state_o, got, jump_addr_o, st, ctl, ea);
        end
    endtask

    task automatic step(input logic [4:0] ev, input logic [AW-1:0] ja, input logic [17:0] hz);
        @(posedge clk);
        #1;
        apply(ev, ja, hz);
        @(negedge clk);
    endtask

    vec_t tbl[$];

    initial begin
        logic [17:0] z;
        z = '0;

        // state column is the state seen before the cycle's clock edge
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd0, NONE,      12'h000)); // idle
        tbl.push_back(mk(E_J,         12'h040, z, 2'd0, C_J | FL2, 12'h040)); // jump
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd1, FL2,       12'h000)); // flush cycle 1
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd0, NONE,      12'h000)); // back to RUN
        tbl.push_back(mk(5'd0, 12'h000, hzv(1, 5'd5, 5'd0, 0, 5'd5, 1), 2'd0, BUB,  12'h000)); // load-use rs2
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd0, NONE,      12'h000)); // single bubble only
        tbl.push_back(mk(5'd0, 12'h000, hzv(1, 5'd0, 5'd0, 1, 5'd0, 1), 2'd0, NONE, 12'h000)); // rd=x0
        tbl.push_back(mk(5'd0, 12'h000, hzv(1, 5'd5, 5'd0, 0, 5'd5, 0), 2'd0, NONE, 12'h000)); // rs2 unused
        tbl.push_back(mk(5'd0, 12'h000, hzv(1, 5'd5, 5'd5, 1, 5'd0, 0), 2'd0, BUB,  12'h000)); // load-use rs1
        tbl.push_back(mk(5'd0, 12'h000, hzv(0, 5'd5, 5'd5, 1, 5'd5, 1), 2'd0, NONE, 12'h000)); // not a load
        tbl.push_back(mk(E_REQ,       12'h000, z, 2'd0, HOLD3,     12'h000)); // mem entry
        tbl.push_back(mk(E_REQ,       12'h000, z, 2'd3, HOLD3,     12'h000));
        tbl.push_back(mk(E_REQ,       12'h000, z, 2'd3, HOLD3,     12'h000));
        tbl.push_back(mk(E_REQ,       12'h000, z, 2'd3, HOLD3,     12'h000));
        tbl.push_back(mk(E_REQ|E_ACK, 12'h000, z, 2'd3, NONE,      12'h000)); // ack releases
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd0, NONE,      12'h000));
        tbl.push_back(mk(E_REQ|E_ACK, 12'h000, z, 2'd0, NONE,      12'h000)); // same-cycle ack
        tbl.push_back(mk(E_MCS,       12'h000, z, 2'd0, HOLD3,     12'h000)); // mc entry
        tbl.push_back(mk(E_MCD,       12'h000, z, 2'd2, NONE,      12'h000)); // mc done
        tbl.push_back(mk(E_MCS|E_MCD, 12'h000, z, 2'd0, NONE,      12'h000)); // same-cycle done
        tbl.push_back(mk(E_J|E_REQ, 12'h123, hzv(1, 5'd7, 5'd7, 1, 5'd0, 0), 2'd0, C_J | FL2, 12'h123)); // priority
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd1, FL2,       12'h000));
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd0, NONE,      12'h000));
        tbl.push_back(mk(E_J,         12'h0AA, z, 2'd0, C_J | FL2, 12'h0AA));
        tbl.push_back(mk(E_J,         12'h0BB, z, 2'd1, C_J | FL2, 12'h0BB)); // jump in FLUSH reloads
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd1, FL2,       12'h000));
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd0, NONE,      12'h000));
        tbl.push_back(mk(E_REQ,       12'h000, z, 2'd0, HOLD3,     12'h000));
        tbl.push_back(mk(E_J|E_REQ,   12'h0CC, z, 2'd3, HOLD3,     12'h000)); // jump ignored in WAIT
        tbl.push_back(mk(E_REQ|E_ACK, 12'h000, z, 2'd3, NONE,      12'h000));
        tbl.push_back(mk(5'd0,        12'h000, z, 2'd0, NONE,      12'h000));

        // reset: outputs gated even with requests present
        rst = 1'b1;
        apply(E_J | E_REQ, 12'h040, hzv(1, 5'd5, 5'd5, 1, 5'd5, 1));
        #3;
        check("reset_state", 2'd0, NONE, 12'h000);
        @(negedge clk);
        apply(5'd0, 12'h000, z);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].ev, tbl[i].ja, tbl[i].hz);
            check($sformatf("vec%0d", i), tbl[i].st, tbl[i].ctl, tbl[i].ea);
        end

        // watchdog: mc op never completes, TIMEOUT=8
        step(E_MCS, 12'h000, z);
        check("wd_entry", 2'd0, HOLD3, 12'h000);
        for (int i = 1; i < 8; i++) begin
            step(5'd0, 12'h000, z);
            check($sformatf("wd_wait%0d", i), 2'd2, HOLD3, 12'h000);
        end
        step(5'd0, 12'h000, z);
        check("wd_expire", 2'd2, FL2 | C_ERR, 12'h000);
        for (int i = 0; i < 3; i++) begin
            step(5'd0, 12'h000, z);
            check($sformatf("wd_sticky%0d", i), 2'd0, C_ERR, 12'h000);
        end

        // asynchronous reset while in WAIT_MEM
        step(E_REQ, 12'h000, z);
        check("rst_pre_entry", 2'd0, HOLD3 | C_ERR, 12'h000);
        step(E_REQ, 12'h000, z);
        check("rst_pre_wait", 2'd3, HOLD3 | C_ERR, 12'h000);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 2'd0, NONE, 12'h000);
        @(posedge clk);
        #1;
        apply(5'd0, 12'h000, z);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle0", 2'd0, NONE, 12'h000);
        for (int i = 1; i < 3; i++) begin
            step(5'd0, 12'h000, z);
            check($sformatf("rst_idle%0d", i), 2'd0, NONE, 12'h000);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
